// File: rtl/swerv_types.sv
// swerv_types: shared branch predictor packet types for the execute and predict pipes
package swerv_types;
    localparam int BP_IDX_W = 8;
    typedef struct packed {
        logic                valid;
        logic                taken;
        logic [1:0]          hist;
        logic [BP_IDX_W-1:0] index;
        logic                way;
    } predict_pkt_t;
    typedef struct packed {
        logic                misp;
        logic                ataken;
        logic [1:0]          hist;
        logic [BP_IDX_W-1:0] index;
        logic                way;
    } bp_upd_pkt_t;
endpackage

// File: rtl/exu_bp_upd_fifo.sv
// exu_bp_upd_fifo: circular FIFO storage with pointers, occupancy and zeroed output when empty
module exu_bp_upd_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 13
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW:0]   occ;
    logic          do_push, do_pop;
    always_comb begin
        do_pop  = pop & ~empty;
        do_push = push & (~full | do_pop);
    end
    assign full  = occ == (PW+1)'(DEPTH);
    assign empty = occ == '0;
    assign dout  = empty ? '0 : mem[rd_ptr];
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            occ <= occ + (PW+1)'(do_push) - (PW+1)'(do_pop);
        end
    end
    always_ff @(posedge clk) begin
        if (do_push & ~rst) mem[wr_ptr] <= din;
    end
endmodule

// File: rtl/exu_bp_upd_queue.sv
// exu_bp_upd_queue: buffers resolved-branch predictor updates and counts accepted, mispredicted and dropped resolutions
module exu_bp_upd_queue
    import swerv_types::*;
#(
    parameter int DEPTH = 4,
    parameter int IDX_W = BP_IDX_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             res_valid,
    input  logic             res_misp,
    input  logic             res_ataken,
    input  logic [1:0]       res_hist,
    input  logic [IDX_W-1:0] res_index,
    input  logic             res_way,
    input  logic             flush,
    input  logic             freeze,
    input  logic             upd_ready,
    output logic             upd_valid,
    output bp_upd_pkt_t      upd_pkt,
    output logic             q_full,
    output logic             q_empty,
    output logic [31:0]      cnt_resolved,
    output logic [31:0]      cnt_misp,
    output logic [15:0]      cnt_drop
);
    localparam int W = $bits(bp_upd_pkt_t);
    logic         push, pop, accept, drop;
    bp_upd_pkt_t  in_pkt;
    logic [W-1:0] head;
    always_comb begin
        push   = res_valid & ~flush & ~freeze;
        pop    = upd_valid & upd_ready;
        accept = push & (~q_full | pop);
        drop   = push & q_full & ~pop;
        in_pkt = '{misp: res_misp, ataken: res_ataken, hist: res_hist, index: res_index, way: res_way};
    end
    exu_bp_upd_fifo #(.DEPTH(DEPTH), .W(W)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (in_pkt),
        .dout  (head),
        .full  (q_full),
        .empty (q_empty)
    );
    assign upd_valid = ~q_empty;
    assign upd_pkt   = bp_upd_pkt_t'(head);
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_resolved <= '0;
            cnt_misp     <= '0;
            cnt_drop     <= '0;
        end else begin
            cnt_resolved <= cnt_resolved + 32'(accept);
            cnt_misp     <= cnt_misp + 32'(accept & res_misp);
            cnt_drop     <= cnt_drop + 16'(drop & ~&cnt_drop);
        end
    end
endmodule

// File: tb/tb_exu_bp_upd_queue.sv
// tb_exu_bp_upd_queue: directed scoreboard bench for the branch predictor update queue
module tb_exu_bp_upd_queue;
    import swerv_types::*;
    logic        clk = 0;
    logic        rst, res_valid, res_misp, res_ataken, res_way, flush, freeze, upd_ready;
    logic [1:0]  res_hist;
    logic [7:0]  res_index;
    logic        upd_valid, q_full, q_empty;
    bp_upd_pkt_t upd_pkt;
    logic [31:0] cnt_resolved, cnt_misp;
    logic [15:0] cnt_drop;
    int          vectors = 0;
    int          miscompares = 0;
    bp_upd_pkt_t sb[$];
    logic [31:0] m_res, m_misp;
    logic [15:0] m_drop;
    always #5 clk = ~clk;
    exu_bp_upd_queue #(.DEPTH(4), .IDX_W(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .res_valid    (res_valid),
        .res_misp     (res_misp),
        .res_ataken   (res_ataken),
        .res_hist     (res_hist),
        .res_index    (res_index),
        .res_way      (res_way),
        .flush        (flush),
        .freeze       (freeze),
        .upd_ready    (upd_ready),
        .upd_valid    (upd_valid),
        .upd_pkt      (upd_pkt),
        .q_full       (q_full),
        .q_empty      (q_empty),
        .cnt_resolved (cnt_resolved),
        .cnt_misp     (cnt_misp),
        .cnt_drop     (cnt_drop)
    );
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    function automatic bp_upd_pkt_t mk(input logic m, input logic a, input logic [1:0] h, input logic [7:0] i, input logic w);
        return '{misp: m, ataken: a, hist: h, index: i, way: w};
    endfunction
    task automatic chk_cnt();
        chk("cnt_resolved", cnt_resolved, m_res);
        chk("cnt_misp", cnt_misp, m_misp);
        chk("cnt_drop", cnt_drop, {16'h0, m_drop});
    endtask
    task automatic step(input logic rv, input bp_upd_pkt_t p, input logic fl, input logic fr, input logic rdy);
        logic popped, was_full;
        res_valid = rv;
        {res_misp, res_ataken, res_hist, res_index, res_way} = p;
        flush = fl;
        freeze = fr;
        upd_ready = rdy;
        #1;
        chk("upd_valid", upd_valid, sb.size() != 0);
        chk("upd_pkt", upd_pkt, sb.size() != 0 ? sb[0] : bp_upd_pkt_t'(0));
        chk("q_full", q_full, sb.size() == 4);
        chk("q_empty", q_empty, sb.size() == 0);
        was_full = sb.size() == 4;
        popped = sb.size() != 0 && rdy;
        if (popped) void'(sb.pop_front());
        if (rv && !fl && !fr) begin
            if (!was_full || popped) begin
                sb.push_back(p);
                m_res++;
                if (p.misp) m_misp++;
            end else if (m_drop != 16'hFFFF) m_drop++;
        end
        @(posedge clk);
        #1;
        chk_cnt();
    endtask
    task automatic idle(input logic rdy);
        step(1'b0, '0, 1'b0, 1'b0, rdy);
    endtask
    task automatic push_n(input int n, input logic [7:0] base, input logic rdy);
        for (int i = 0; i < n; i++)
            step(1'b1, mk(i[0], ~i[0], 2'(i), base + 8'(i), i[1]), 1'b0, 1'b0, rdy);
    endtask
    initial begin
        rst = 1;
        m_res = 0;
        m_misp = 0;
        m_drop = 0;
        res_valid = 0;
        {res_misp, res_ataken, res_hist, res_index, res_way} = '0;
        flush = 0;
        freeze = 0;
        upd_ready = 0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 0;
        idle(1'b1);
        step(1'b1, mk(1, 1, 2'b11, 8'h3C, 0), 1'b0, 1'b0, 1'b1);
        idle(1'b1);
        idle(1'b1);
        push_n(5, 8'h01, 1'b0);
        for (int i = 0; i < 5; i++) idle(1'b1);
        push_n(4, 8'h10, 1'b0);
        idle(1'b0);
        step(1'b1, mk(0, 1, 2'b01, 8'h09, 1), 1'b0, 1'b0, 1'b1);
        idle(1'b0);
        for (int i = 0; i < 5; i++) idle(1'b1);
        step(1'b1, mk(1, 0, 2'b10, 8'h20, 0), 1'b0, 1'b0, 1'b0);
        step(1'b1, mk(1, 1, 2'b11, 8'h21, 1), 1'b1, 1'b0, 1'b0);
        step(1'b1, mk(1, 1, 2'b11, 8'h22, 1), 1'b0, 1'b1, 1'b1);
        idle(1'b1);
        push_n(3, 8'h40, 1'b0);
        rst = 1;
        res_valid = 1;
        upd_ready = 1;
        @(posedge clk);
        #1;
        rst = 0;
        sb.delete();
        m_res = 0;
        m_misp = 0;
        m_drop = 0;
        idle(1'b0);
        push_n(4, 8'h50, 1'b0);
        force dut.cnt_drop = 16'hFFFE;
        #1;
        release dut.cnt_drop;
        m_drop = 16'hFFFE;
        chk("cnt_drop_preset", cnt_drop, {16'h0, m_drop});
        push_n(2, 8'h60, 1'b0);
        idle(1'b0);
        for (int i = 0; i < 60; i++)
            step(1'($urandom_range(0, 1)), mk(1'($urandom), 1'($urandom), 2'($urandom), 8'($urandom), 1'($urandom)),
                 $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0, 1'($urandom_range(0, 2) != 0));
        for (int i = 0; i < 5; i++) idle(1'b1);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/exu_bp_upd_queue.md
EXU_BP_UPD_QUEUE -- requirements
Module: exu_bp_upd_queue

Interface
REQ-001 Parameter DEPTH, default 4, queue entries; power of two, 2..16.
REQ-002 Parameter IDX_W, default 8, predictor index width.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 res_valid  input  1  branch resolved this cycle (ALU stage valid, branch-class op).
REQ-006 res_misp  input  1  resolved branch mispredicted (condition or target).
REQ-007 res_ataken  input  1  actual taken outcome.
REQ-008 res_hist  input  2  updated 2-bit counter value for the predictor entry.
REQ-009 res_index  input  IDX_W  predictor index of the branch.
REQ-010 res_way  input  1  predictor way of the branch.
REQ-011 flush  input  1  lower-pipe flush; kills the same-cycle resolution.
REQ-012 freeze  input  1  pipeline freeze; blocks capture, not drain.
REQ-013 upd_ready  input  1  predictor accepts an update this cycle.
REQ-014 upd_valid  output  1  head entry presented to predictor.
REQ-015 upd_pkt  output  bp_upd_pkt_t  head payload {misp, ataken, hist, index, way}.
REQ-016 q_full  output  1  occupancy == DEPTH.
REQ-017 q_empty  output  1  occupancy == 0.
REQ-018 cnt_resolved  output  32  accepted resolutions.
REQ-019 cnt_misp  output  32  accepted resolutions with misp=1.
REQ-020 cnt_drop  output  16  resolutions lost to full queue.

Function
REQ-021 push = res_valid & ~flush & ~freeze; pop = upd_valid & upd_ready.
REQ-022 Push SHALL be accepted when occupancy < DEPTH, or occupancy == DEPTH with pop in the same cycle.
REQ-023 Push when full without pop SHALL drop the resolution, leave the queue unchanged, and increment cnt_drop.
REQ-024 Queue SHALL be strict FIFO; circular read/write pointers wrap modulo DEPTH; occupancy tracked in log2(DEPTH)+1 bits.
REQ-025 Entry pushed in cycle N SHALL appear at upd_valid no earlier than cycle N+1 (no combinational input-to-output path).
REQ-026 upd_valid = ~q_empty; upd_pkt SHALL be all-zero when empty.
REQ-027 upd_pkt SHALL be stable while upd_valid=1 and upd_ready=0.
REQ-028 Simultaneous push and pop SHALL leave occupancy unchanged (any non-empty occupancy, including full).
REQ-029 Push into empty queue with pop same cycle is impossible (upd_valid=0); entry stored, presented next cycle.
REQ-030 flush and freeze SHALL NOT clear or stall queued entries; drain continues.
REQ-031 cnt_resolved and cnt_misp SHALL increment on accepted pushes only; wrap modulo 2^32.
REQ-032 cnt_drop SHALL saturate at 16'hFFFF.

Reset
REQ-033 rst=1 at an edge SHALL set pointers and occupancy to 0, all counters to 0, upd_valid=0, upd_pkt=0, q_empty=1, q_full=0.
REQ-034 Resolutions and pops during a reset cycle SHALL be ignored; queued entries at reset are discarded.
REQ-035 Entry payload storage need not be reset; outputs SHALL still be zero while empty.

Structure
REQ-036 bp_upd_pkt_t typedef SHALL be defined in swerv_types alongside predict_pkt_t.
REQ-037 Storage+pointers SHALL be one sub-module, exu_bp_upd_fifo, parameterised by DEPTH and payload width; counters and push/drop logic in the top.
REQ-038 Target 150-300 lines RTL total.

Verification
REQ-039 Reset, then one push {misp=1,ataken=1,hist=2'b11,index=8'h3C,way=0}, upd_ready=1 -> upd_valid=1 exactly next cycle with that payload, then q_empty=1; cnt_resolved=1, cnt_misp=1.
REQ-040 upd_ready=0, 5 consecutive pushes (index 1..5), DEPTH=4 -> q_full=1 after 4th, cnt_drop=1; then drain -> indices 1,2,3,4 in order.
REQ-041 Full queue, push and pop same cycle -> occupancy stays 4, q_full=1, cnt_drop unchanged, new index appears last.
REQ-042 res_valid=1 with flush=1, then with freeze=1 -> no push, counters unchanged; queued entry still drains with upd_ready=1.
REQ-043 3 entries queued, rst asserted 1 cycle with res_valid=1 and upd_ready=1 -> next cycle upd_valid=0, all counters 0.
REQ-044 Force cnt_drop=16'hFFFE, two drops -> cnt_drop=16'hFFFF and holds.
